// File: rtl/neopixel_strand_decoder.sv
// Receive-side NeoPixel decoder: classifies high pulses on the synchronised line
// as 0/1 bits, assembles 24-bit GRB words and flags frame end, bad pulses and overflow.
module neopixel_strand_decoder #(
    parameter int NUM_PIXELS   = 5,
    parameter int IDX_W        = 3,
    parameter int T_BIT_THRESH = 26,
    parameter int T_HIGH_MIN   = 8,
    parameter int T_HIGH_MAX   = 50,
    parameter int T_LATCH      = 2500
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             neo_data,
    output logic             pixel_valid,
    output logic [IDX_W-1:0] pixel_index,
    output logic [7:0]       green,
    output logic [7:0]       red,
    output logic [7:0]       blue,
    output logic             frame_done,
    output logic             pulse_error,
    output logic             overflow,
    output logic             busy
);

    localparam int HC_W = $clog2(T_HIGH_MAX + 2);
    localparam int LC_W = 12;
    localparam int PC_W = $clog2(NUM_PIXELS + 1);

    localparam logic [HC_W-1:0] HC_MIN = HC_W'(T_HIGH_MIN);
    localparam logic [HC_W-1:0] HC_MAX = HC_W'(T_HIGH_MAX);
    localparam logic [HC_W-1:0] HC_THR = HC_W'(T_BIT_THRESH);
    localparam logic [HC_W-1:0] HC_SAT = HC_W'(T_HIGH_MAX + 1);
    localparam logic [LC_W-1:0] LC_END = LC_W'(T_LATCH - 1);
    localparam logic [LC_W-1:0] LC_SAT = LC_W'(T_LATCH);
    localparam logic [PC_W-1:0] PC_MAX = PC_W'(NUM_PIXELS);

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync2_q, line_prev_q;
    logic [HC_W-1:0]   high_cnt_q, high_cnt_d;
    logic [LC_W-1:0]   low_cnt_q, low_cnt_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [23:0]       word_q, word_d;
    logic [PC_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [7:0]        green_q, green_d;
    logic [7:0]        red_q, red_d;
    logic [7:0]        blue_q, blue_d;

    logic              line;
    logic              rise;
    logic              fall;
    logic [23:0]       shifted;

    assign line = sync2_q;
    assign rise = line & ~line_prev_q;
    assign fall = ~line & line_prev_q;
    // First received bit ends up in word[0] after 24 right shifts.
    assign shifted = {(high_cnt_q > HC_THR), word_q[23:1]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= SYNC;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            line_prev_q <= 1'b0;
            high_cnt_q  <= '0;
            low_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            word_q      <= '0;
            pix_cnt_q   <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            index_q     <= '0;
            green_q     <= '0;
            red_q       <= '0;
            blue_q      <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= neo_data;
            sync2_q     <= sync1_q;
            line_prev_q <= sync2_q;
            high_cnt_q  <= high_cnt_d;
            low_cnt_q   <= low_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            word_q      <= word_d;
            pix_cnt_q   <= pix_cnt_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            index_q     <= index_d;
            green_q     <= green_d;
            red_q       <= red_d;
            blue_q      <= blue_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        high_cnt_d = high_cnt_q;
        low_cnt_d  = low_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        word_d     = word_q;
        pix_cnt_d  = pix_cnt_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        ovf_d      = 1'b0;
        index_d    = index_q;
        green_d    = green_q;
        red_d      = red_q;
        blue_d     = blue_q;

        unique case (state_q)
            SYNC: begin
                if (line) begin
                    low_cnt_d = '0;
                end else if (low_cnt_q >= LC_END) begin
                    low_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    low_cnt_d = low_cnt_q + LC_W'(1);
                end
            end

            IDLE: begin
                if (rise) begin
                    state_d    = HIGH;
                    high_cnt_d = HC_W'(1);
                    busy_d     = 1'b1;
                end
            end

            HIGH: begin
                if (fall) begin
                    if (high_cnt_q < HC_MIN || high_cnt_q > HC_MAX) begin
                        err_d     = 1'b1;
                        busy_d    = 1'b0;
                        bit_cnt_d = '0;
                        word_d    = '0;
                        pix_cnt_d = '0;
                        low_cnt_d = LC_W'(1);
                        state_d   = SYNC;
                    end else begin
                        word_d    = shifted;
                        low_cnt_d = LC_W'(1);
                        state_d   = LOW;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = '0;
                            if (pix_cnt_q < PC_MAX) begin
                                valid_d   = 1'b1;
                                index_d   = IDX_W'(pix_cnt_q);
                                green_d   = shifted[23:16];
                                red_d     = shifted[15:8];
                                blue_d    = shifted[7:0];
                                pix_cnt_d = pix_cnt_q + PC_W'(1);
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end else if (high_cnt_q != HC_SAT) begin
                    high_cnt_d = high_cnt_q + HC_W'(1);
                end
            end

            LOW: begin
                if (rise) begin
                    state_d    = HIGH;
                    high_cnt_d = HC_W'(1);
                end else if (low_cnt_q >= LC_END) begin
                    // Latch gap: a partially filled word is reported and dropped.
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    pix_cnt_d = '0;
                    low_cnt_d = LC_SAT;
                    state_d   = IDLE;
                    if (bit_cnt_q != 5'd0) begin
                        err_d     = 1'b1;
                        bit_cnt_d = '0;
                        word_d    = '0;
                    end
                end else begin
                    low_cnt_d = low_cnt_q + LC_W'(1);
                end
            end

            default: state_d = SYNC;
        endcase
    end

    assign pixel_valid = valid_q;
    assign pixel_index = index_q;
    assign green       = green_q;
    assign red         = red_q;
    assign blue        = blue_q;
    assign frame_done  = done_q;
    assign pulse_error = err_q;
    assign overflow    = ovf_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_neopixel_strand_decoder.sv
// Scoreboard bench for neopixel_strand_decoder: expected strobes are queued as the
// line is driven and popped whenever the decoder raises a strobe.
module tb_neopixel_strand_decoder;

    localparam int IDX_W = 3;

    localparam logic [3:0] EV_PIX  = 4'b1000;
    localparam logic [3:0] EV_OVF  = 4'b0100;
    localparam logic [3:0] EV_FD   = 4'b0010;
    localparam logic [3:0] EV_PE   = 4'b0001;
    localparam logic [3:0] EV_FDPE = 4'b0011;

    logic             clock;
    logic             reset_n;
    logic             neo_data;
    logic             pixel_valid;
    logic [IDX_W-1:0] pixel_index;
    logic [7:0]       green;
    logic [7:0]       red;
    logic [7:0]       blue;
    logic             frame_done;
    logic             pulse_error;
    logic             overflow;
    logic             busy;

    typedef struct {
        logic [3:0]       kind;
        logic [IDX_W-1:0] idx;
        logic [23:0]      word;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    neopixel_strand_decoder dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .neo_data    (neo_data),
        .pixel_valid (pixel_valid),
        .pixel_index (pixel_index),
        .green       (green),
        .red         (red),
        .blue        (blue),
        .frame_done  (frame_done),
        .pulse_error (pulse_error),
        .overflow    (overflow),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic push_ev(input logic [3:0] kind, input logic [IDX_W-1:0] idx, input logic [23:0] word);
        ev_t e;
        e.kind = kind;
        e.idx  = idx;
        e.word = word;
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input int hi, input int lo);
        neo_data = 1'b1;
        repeat (hi) @(negedge clock);
        neo_data = 1'b0;
        repeat (lo) @(negedge clock);
    endtask

    task automatic send_std(input logic b);
        if (b) send_bit(35, 30);
        else   send_bit(18, 40);
    endtask

    // Bits go out LSB first so word bit k is the k-th bit on the wire.
    task automatic send_bits(input logic [23:0] w, input int n);
        for (int k = 0; k < n; k++) send_std(w[k]);
    endtask

    task automatic send_pix(input logic [23:0] w, input logic [IDX_W-1:0] idx);
        push_ev(EV_PIX, idx, w);
        send_bits(w, 24);
    endtask

    task automatic gap(input int n);
        neo_data = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (reset_n && (pixel_valid || overflow || frame_done || pulse_error)) begin
            logic [3:0] got;
            got = {pixel_valid, overflow, frame_done, pulse_error};
            if (exp_q.size() == 0) begin
                check("spurious_strobe", {60'd0, got}, 64'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("strobe_kind", {60'd0, got}, {60'd0, e.kind});
                if (e.kind == EV_PIX) begin
                    check("pix_index", {61'd0, pixel_index}, {61'd0, e.idx});
                    check("pix_grb", {40'd0, green, red, blue}, {40'd0, e.word});
                end
                check("busy_at_strobe", {63'd0, busy},
                      {63'd0, (e.kind == EV_PIX || e.kind == EV_OVF)});
            end
        end
    end

    initial begin
        logic [23:0] frame5 [5];
        logic [23:0] w;
        int          hi [4];

        frame5[0] = 24'h000001;
        frame5[1] = 24'h800000;
        frame5[2] = 24'hFFFFFF;
        frame5[3] = 24'h000000;
        frame5[4] = 24'h123456;

        reset_n  = 1'b0;
        neo_data = 1'b0;
        repeat (5) @(negedge clock);
        check("reset_outputs",
              {34'd0, pixel_valid, overflow, frame_done, pulse_error, busy, pixel_index, green, red, blue},
              64'd0);
        reset_n = 1'b1;

        // Single pixel after the initial sync gap.
        gap(2600);
        push_ev(EV_PIX, 0, 24'hA53C0F);
        send_std(1'b1);
        check("busy_in_frame", {63'd0, busy}, 64'd1);
        send_bits(24'hA53C0F >> 1, 23);
        push_ev(EV_FD, 0, 0);
        gap(2600);
        check("hold_grb", {40'd0, green, red, blue}, {40'd0, 24'hA53C0F});
        check("busy_after_frame", {63'd0, busy}, 64'd0);

        // Full frame of NUM_PIXELS words.
        for (int p = 0; p < 5; p++) begin
            send_pix(frame5[p], IDX_W'(p));
            check("busy_mid_frame", {63'd0, busy}, 64'd1);
        end
        push_ev(EV_FD, 0, 0);
        gap(2600);

        // One word beyond the frame length.
        for (int p = 0; p < 5; p++) send_pix(24'h100000 + 24'(p * 3 + 1), IDX_W'(p));
        push_ev(EV_OVF, 0, 0);
        send_bits(24'hC0FFEE, 24);
        push_ev(EV_FD, 0, 0);
        gap(2600);

        // Boundary high widths 26, 27, 8, 50 in the first four bits.
        hi[0] = 26; hi[1] = 27; hi[2] = 8; hi[3] = 50;
        w = 24'h5A5A50;
        for (int k = 0; k < 4; k++) w[k] = (hi[k] > 26);
        push_ev(EV_PIX, 0, w);
        for (int k = 0; k < 4; k++) send_bit(hi[k], 30);
        for (int k = 4; k < 24; k++) send_std(w[k]);
        push_ev(EV_FD, 0, 0);
        gap(2600);

        // Too-short pulse, then an ignored burst, then recovery.
        send_std(1'b1);
        push_ev(EV_PE, 0, 0);
        send_bit(7, 30);
        check("busy_after_short", {63'd0, busy}, 64'd0);
        send_bits(24'hFFFFFF, 8);
        gap(2600);
        send_pix(24'h0F0F0F, 0);
        push_ev(EV_FD, 0, 0);
        gap(2600);

        // Too-long pulse.
        push_ev(EV_PE, 0, 0);
        send_bit(51, 30);
        check("busy_after_long", {63'd0, busy}, 64'd0);
        send_bits(24'hAAAAAA, 8);
        gap(2600);

        // Partial word at latch: frame_done and pulse_error together.
        send_bits(24'h3FF, 10);
        push_ev(EV_FDPE, 0, 0);
        gap(2600);
        send_pix(24'h654321, 0);
        push_ev(EV_FD, 0, 0);
        gap(2600);

        // Reset mid-word, then a frame without a preceding gap is ignored.
        send_bits(24'hFFFFFF, 10);
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("midreset_outputs",
              {34'd0, pixel_valid, overflow, frame_done, pulse_error, busy, pixel_index, green, red, blue},
              64'd0);
        reset_n = 1'b1;
        send_bits(24'h777777, 8);
        gap(2600);
        send_pix(24'hDEAD42, 0);
        send_pix(24'h0BEEF0, 1);
        push_ev(EV_FD, 0, 0);
        gap(2600);

        check("events_left", {32'd0, 32'(exp_q.size())}, 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
